// File: rtl/scbd_feeder_rr_if.sv
`default_nettype none
// ============================================================================
// Module   : scbd_feeder_rr_if
// Brief    : Wavepool-to-scoreboard feeder bus. Carries the per-wavefront
//            status vectors, the half-slot credit strobe and the registered
//            feed valid/ready handshake with its credit status.
// Revision : 1.0 - initial release
// ============================================================================
interface scbd_feeder_rr_if #(
    parameter int NUM_WF = 40,
    parameter int WFID_W = 6
);
    logic [NUM_WF-1:0] valid_wf;
    logic [NUM_WF-1:0] q_empty;
    logic [NUM_WF-1:0] q_reset;
    logic [NUM_WF-1:0] issue_vacant;
    logic              ins_half_reqd;
    logic [WFID_W-1:0] ins_half_wfid;
    logic              feed_ready;
    logic              feed_valid;
    logic [WFID_W-1:0] feed_wfid;
    logic [NUM_WF-1:0] hungry;

    // Wavepool / issue side: drives status and consumes the feed
    modport master (
        output valid_wf, q_empty, q_reset, issue_vacant,
        output ins_half_reqd, ins_half_wfid, feed_ready,
        input  feed_valid, feed_wfid, hungry
    );

    // Feeder side
    modport slave (
        input  valid_wf, q_empty, q_reset, issue_vacant,
        input  ins_half_reqd, ins_half_wfid, feed_ready,
        output feed_valid, feed_wfid, hungry
    );
endinterface
`default_nettype wire

// File: rtl/scbd_feeder_rr.sv
`default_nettype none
// ============================================================================
// Module   : scbd_feeder_rr
// Brief    : Wavefront feeder between the wavepool instruction queues and the
//            scoreboard/issue stage. Tracks per-wavefront saturating credits
//            for free scoreboard slots and presents one eligible wavefront ID
//            per cycle on a registered valid/ready output.
//            Macro SCBD_FEEDER_RR_EN: defined -> round-robin arbitration,
//            undefined -> fixed priority (lowest eligible index wins).
// Revision : 1.0 - initial release
// ============================================================================
module scbd_feeder_rr #(
    parameter int NUM_WF     = 40,
    parameter int WFID_W     = 6,
    parameter int CREDIT_W   = 2,
    parameter int MAX_CREDIT = 2
) (
    input  wire logic        clk,
    input  wire logic        rst,
    scbd_feeder_rr_if.slave  bus
);

    localparam int                  c_sum_w      = CREDIT_W + 2;
    localparam logic [CREDIT_W-1:0] c_max_credit = CREDIT_W'(MAX_CREDIT);
    localparam logic [c_sum_w-1:0]  c_max_wide   = c_sum_w'(MAX_CREDIT);
    localparam logic [WFID_W-1:0]   c_last_wf    = WFID_W'(NUM_WF - 1);

    logic [CREDIT_W-1:0] r_credit     [NUM_WF];
    logic [CREDIT_W-1:0] w_credit_nxt [NUM_WF];
    logic                r_feed_valid;
    logic [WFID_W-1:0]   r_feed_wfid;

    logic [NUM_WF-1:0]   w_eligible;
    logic [NUM_WF-1:0]   w_grant;
    logic [NUM_WF-1:0]   w_half_hit;
    logic [NUM_WF-1:0]   w_hungry;
    logic                w_load;
    logic                w_any;
    logic                w_cancel;
    logic [WFID_W-1:0]   w_winner;

    // Lowest set index of a request vector; returns 0 for an empty vector,
    // callers qualify the result with their own "any" flag.
    function automatic logic [WFID_W-1:0] f_lowest(input logic [NUM_WF-1:0] vec);
        logic [WFID_W-1:0] w_idx;
        w_idx = '0;
        for (int i = NUM_WF - 1; i >= 0; i--) begin
            if (vec[i]) begin
                w_idx = WFID_W'(i);
            end
        end
        return w_idx;
    endfunction

    // Per-wavefront eligibility, credit status and half-slot strobe decode.
    // An out-of-range ins_half_wfid never matches any slot, so it is ignored.
    always_comb begin
        for (int i = 0; i < NUM_WF; i++) begin
            w_hungry[i]   = (r_credit[i] != '0);
            w_eligible[i] = (r_credit[i] != '0) & ~bus.q_empty[i]
                          & bus.valid_wf[i] & ~bus.q_reset[i];
            w_half_hit[i] = bus.ins_half_reqd & (bus.ins_half_wfid == WFID_W'(i));
        end
    end

    // The output register may take a new entry when empty or being drained
    assign w_load = ~r_feed_valid | bus.feed_ready;
    assign w_any  = |w_eligible;

`ifdef SCBD_FEEDER_RR_EN
    logic [WFID_W-1:0] r_rr_ptr;
    logic [NUM_WF-1:0] w_upper_elig;

    // Round-robin pick: lowest eligible at or above the pointer, else wrap
    // around to the lowest eligible overall.
    always_comb begin
        for (int i = 0; i < NUM_WF; i++) begin
            w_upper_elig[i] = w_eligible[i] & (i >= int'(r_rr_ptr));
        end
        w_winner = (|w_upper_elig) ? f_lowest(w_upper_elig) : f_lowest(w_eligible);
    end

    // Pointer moves just past each accepted winner, wrapping at the last slot
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rr_ptr <= '0;
        end else if (w_load && w_any) begin
            r_rr_ptr <= (w_winner == c_last_wf) ? '0 : w_winner + 1'b1;
        end
    end
`else
    // Fixed priority pick: lowest eligible index wins
    always_comb begin
        w_winner = f_lowest(w_eligible);
    end
`endif

    // One-hot grant: only when the output register actually takes the winner
    always_comb begin
        for (int i = 0; i < NUM_WF; i++) begin
            w_grant[i] = w_load & w_any & (w_winner == WFID_W'(i));
        end
    end

    // A flush of the wavefront sitting stalled in the output register
    // withdraws that entry before it can be transferred.
    always_comb begin
        w_cancel = 1'b0;
        for (int i = 0; i < NUM_WF; i++) begin
            if ((r_feed_wfid == WFID_W'(i)) && bus.q_reset[i]) begin
                w_cancel = 1'b1;
            end
        end
        w_cancel = w_cancel & r_feed_valid & ~bus.feed_ready;
    end

    // Credit next-state: flush reloads the ceiling; otherwise both increments
    // and the grant decrement combine in a wider sum before saturating, so a
    // +2/-1 cycle nets +1 and never wraps.
    always_comb begin
        logic [c_sum_w-1:0] w_sum;
        for (int i = 0; i < NUM_WF; i++) begin
            w_sum = c_sum_w'(r_credit[i])
                  + c_sum_w'(bus.issue_vacant[i])
                  + c_sum_w'(w_half_hit[i]);
            if (w_grant[i] && (w_sum != '0)) begin
                w_sum = w_sum - 1'b1;
            end
            if (bus.q_reset[i]) begin
                w_credit_nxt[i] = c_max_credit;
            end else if (w_sum > c_max_wide) begin
                w_credit_nxt[i] = c_max_credit;
            end else begin
                w_credit_nxt[i] = w_sum[CREDIT_W-1:0];
            end
        end
    end

    // Credit registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_WF; i++) begin
                r_credit[i] <= c_max_credit;
            end
        end else begin
            for (int i = 0; i < NUM_WF; i++) begin
                r_credit[i] <= w_credit_nxt[i];
            end
        end
    end

    // Output register: load a winner, drain to empty, hold under backpressure
    // or drop a stalled entry whose wavefront was flushed.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_feed_valid <= 1'b0;
            r_feed_wfid  <= '0;
        end else if (w_load) begin
            if (w_any) begin
                r_feed_valid <= 1'b1;
                r_feed_wfid  <= w_winner;
            end else begin
                r_feed_valid <= 1'b0;
            end
        end else if (w_cancel) begin
            r_feed_valid <= 1'b0;
        end
    end

    assign bus.feed_valid = r_feed_valid;
    assign bus.feed_wfid  = r_feed_wfid;
    assign bus.hungry     = w_hungry;

endmodule
`default_nettype wire

// File: tb/tb_scbd_feeder_rr.sv
`default_nettype none
// ============================================================================
// Module   : tb_scbd_feeder_rr
// Brief    : Directed self-checking bench for scbd_feeder_rr. Expected feed
//            IDs are queued as stimulus is applied and compared on transfer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_scbd_feeder_rr;

    localparam int NUM_WF     = 40;
    localparam int WFID_W     = 6;
    localparam int CREDIT_W   = 2;
    localparam int MAX_CREDIT = 2;
    localparam logic [NUM_WF-1:0] c_all = '1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   vectors     = 0;
    int   miscompares = 0;
    logic [WFID_W-1:0] sb [$];
    logic [NUM_WF-1:0] mask;

    always #5 clk = ~clk;

    scbd_feeder_rr_if #(.NUM_WF(NUM_WF), .WFID_W(WFID_W)) bus ();

    scbd_feeder_rr #(
        .NUM_WF     (NUM_WF),
        .WFID_W     (WFID_W),
        .CREDIT_W   (CREDIT_W),
        .MAX_CREDIT (MAX_CREDIT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [NUM_WF-1:0] bit_of(input int i);
        logic [NUM_WF-1:0] m;
        m = {{(NUM_WF-1){1'b0}}, 1'b1} << i;
        return m;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input int id);
        sb.push_back(WFID_W'(id));
    endtask

    task automatic idle_inputs();
        bus.valid_wf      = '1;
        bus.q_empty       = '1;
        bus.q_reset       = '0;
        bus.issue_vacant  = '0;
        bus.ins_half_reqd = 1'b0;
        bus.ins_half_wfid = '0;
        bus.feed_ready    = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle_inputs();
        tick(1);
        rst = 1'b1;
    endtask

    task automatic bump9(input logic en);
        bus.issue_vacant  = en ? bit_of(9) : '0;
        bus.ins_half_reqd = en;
        bus.ins_half_wfid = WFID_W'(9);
    endtask

    // Transfer monitor: every accepted entry must match the scoreboard head
    always @(negedge clk) begin
        if (rst && bus.feed_valid && bus.feed_ready) begin
            vectors++;
            assert (sb.size() != 0) else begin
                miscompares++;
                $error("FAIL xfer_unexpected observed wfid=%0d expected=no transfer", bus.feed_wfid);
            end
            if (sb.size() != 0) begin
                chk("xfer_wfid", 64'(bus.feed_wfid), 64'(sb.pop_front()));
            end
        end
    end

    initial begin
        // ---- reset state
        do_reset();
        chk("rst_valid",  64'(bus.feed_valid), 64'(0));
        chk("rst_wfid",   64'(bus.feed_wfid),  64'(0));
        chk("rst_hungry", 64'(bus.hungry),     64'(c_all));

        // ---- two eligible wavefronts drain their credits
        bus.q_empty    = ~(bit_of(3) | bit_of(7));
        bus.feed_ready = 1'b1;
`ifdef SCBD_FEEDER_RR_EN
        push(3); push(7); push(3); push(7);
`else
        push(3); push(3); push(7); push(7);
`endif
        tick(1);
        chk("t1_latency_valid", 64'(bus.feed_valid), 64'(1));
        chk("t1_latency_wfid",  64'(bus.feed_wfid),  64'(3));
        tick(4);
        chk("t1_valid_off", 64'(bus.feed_valid), 64'(0));
        chk("t1_hungry3",   64'(bus.hungry[3]),  64'(0));
        chk("t1_hungry7",   64'(bus.hungry[7]),  64'(0));
        chk("t1_sb_drain",  64'(sb.size()),      64'(0));

        // ---- backpressure: one decrement only while held
        do_reset();
        bus.q_empty = ~bit_of(5);
        push(5); push(5);
        for (int k = 0; k < 4; k++) begin
            tick(1);
            chk("t2_hold_valid", 64'(bus.feed_valid), 64'(1));
            chk("t2_hold_wfid",  64'(bus.feed_wfid),  64'(5));
        end
        chk("t2_hungry5_held", 64'(bus.hungry[5]), 64'(1));
        bus.feed_ready = 1'b1;
        tick(1);
        chk("t2_second_valid", 64'(bus.feed_valid), 64'(1));
        chk("t2_hungry5_zero", 64'(bus.hungry[5]),  64'(0));
        tick(1);
        chk("t2_valid_off", 64'(bus.feed_valid), 64'(0));
        chk("t2_sb_drain",  64'(sb.size()),      64'(0));

        // ---- credit arithmetic on wf 9
        do_reset();
        bus.q_empty    = ~bit_of(9);
        bus.feed_ready = 1'b1;
        push(9); push(9);
        tick(2);
        bus.q_empty = '1;
        tick(1);
        chk("t3_empty_valid",  64'(bus.feed_valid), 64'(0));
        chk("t3_hungry9_zero", 64'(bus.hungry[9]),  64'(0));
        chk("t3_sb_drain_a",   64'(sb.size()),      64'(0));
        // out-of-range half-slot ID changes nothing
        bus.ins_half_reqd = 1'b1;
        bus.ins_half_wfid = WFID_W'(45);
        tick(1);
        bus.ins_half_reqd = 1'b0;
        chk("t6_wfid45_hungry", 64'(bus.hungry), 64'(c_all & ~bit_of(9)));
        // 0 + 1 + 1 -> 2
        bump9(1'b1);
        tick(1);
        bump9(1'b0);
        chk("t3_hungry9_refill", 64'(bus.hungry[9]), 64'(1));
        bus.q_empty = ~bit_of(9);
        push(9);
        tick(1);
        chk("t3_feed9_wfid", 64'(bus.feed_wfid), 64'(9));
        // 1 + 1 + 1 - 1 -> 2 (ceiling)
        bump9(1'b1);
        push(9);
        tick(1);
        bump9(1'b0);
        push(9); push(9);
        tick(3);
        chk("t3_net_valid_off", 64'(bus.feed_valid), 64'(0));
        chk("t3_sb_drain_b",    64'(sb.size()),      64'(0));
        // 0 -> 2 -> saturate at 2 (not wrap)
        bus.q_empty = '1;
        bump9(1'b1);
        tick(2);
        bump9(1'b0);
        bus.q_empty = ~bit_of(9);
        push(9); push(9);
        tick(3);
        chk("t3_sat_valid_off", 64'(bus.feed_valid), 64'(0));
        chk("t3_sb_drain_c",    64'(sb.size()),      64'(0));

        // ---- flush cancels a stalled entry and reloads its credit
        do_reset();
        bus.q_empty = ~bit_of(12);
        tick(1);
        chk("t4_stall_valid", 64'(bus.feed_valid), 64'(1));
        chk("t4_stall_wfid",  64'(bus.feed_wfid),  64'(12));
        bus.q_reset = bit_of(12);
        tick(1);
        chk("t4_cancel_valid", 64'(bus.feed_valid), 64'(0));
        bus.q_reset    = '0;
        bus.feed_ready = 1'b1;
        push(12); push(12);
        tick(3);
        chk("t4_refill_valid_off", 64'(bus.feed_valid), 64'(0));
        chk("t4_sb_drain_a",       64'(sb.size()),      64'(0));
        bus.q_reset = bit_of(12);
        for (int k = 0; k < 3; k++) begin
            tick(1);
            chk("t4_flush_held_valid", 64'(bus.feed_valid), 64'(0));
        end
        bus.q_reset = '0;
        push(12); push(12);
        tick(3);
        chk("t4_release_valid_off", 64'(bus.feed_valid), 64'(0));
        chk("t4_sb_drain_b",        64'(sb.size()),      64'(0));

        // ---- fairness with permanently refilled credits
        do_reset();
        mask             = bit_of(0) | bit_of(1) | bit_of(39);
        bus.q_empty      = ~mask;
        bus.issue_vacant = mask;
        bus.feed_ready   = 1'b1;
`ifdef SCBD_FEEDER_RR_EN
        push(0); push(1); push(39); push(0); push(1); push(39);
`else
        push(0); push(0); push(0); push(0); push(0); push(0);
`endif
        tick(6);
        bus.q_empty      = '1;
        bus.issue_vacant = '0;
        tick(1);
        chk("t5_valid_off", 64'(bus.feed_valid), 64'(0));
        chk("t5_sb_drain",  64'(sb.size()),      64'(0));

        // ---- reset mid-operation discards the pending entry
        do_reset();
        bus.q_empty    = ~bit_of(20);
        bus.feed_ready = 1'b1;
        push(20);
        tick(2);
        bus.feed_ready = 1'b0;
        chk("t7_pending_valid", 64'(bus.feed_valid), 64'(1));
        chk("t7_hungry20_zero", 64'(bus.hungry[20]), 64'(0));
        rst = 1'b0;
        tick(1);
        rst = 1'b1;
        chk("t7_rst_valid",  64'(bus.feed_valid), 64'(0));
        chk("t7_rst_wfid",   64'(bus.feed_wfid),  64'(0));
        chk("t7_rst_hungry", 64'(bus.hungry),     64'(c_all));
        chk("t7_sb_drain",   64'(sb.size()),      64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
